systolic_edge_feeder: RTL and testbench
=======================================

// Module: systolic_edge_feeder
// PURPOSE
//   West-edge transmitter for the systolic PE array. Accepts one ROWS-wide operand vector per beat
//   over a valid/ready handshake and re-times it into the diagonal skew the array needs.
//   Pads stall cycles with zero and emits a per-row skewed done flag after the last beat
//   (drives each row's in_done_flag). Waits out the PE drain latency, then pulses a result-valid strobe.
// PARAMETERS
//   WIDTH        16  element width (FP16 bits; 32 for the FP32 build)
//   ROWS         4   array rows fed = skew depth; ROWS >= 1
//   DRAIN_CYCLES 8   cycles after the last done flag before results are declared valid; >= 1
//   MAX_BEATS    255 saturation value of the beat counter
// PORTS
//   clk              in   1               single clock, rising edge
//   reset            in   1               synchronous, active-high
//   in_valid         in   1               operand vector valid
//   in_ready         out  1               feeder can accept a vector
//   in_data          in   ROWS*WIDTH      element r at [r*WIDTH +: WIDTH]
//   in_last          in   1               qualifies the final vector of a job
//   out_data         out  ROWS*WIDTH      skewed stream to the array west edge, row r slice
//   out_done_flag    out  ROWS            per-row done pulse to the PE in_done_flag
//   out_busy         out  1               state != IDLE
//   out_result_valid out  1               one-cycle strobe: array accumulators are final
//   out_beat_count   out  $clog2(MAX_BEATS+1)  beats accepted in the current/last job, saturating
// BEHAVIOUR
//   Reset: state IDLE; out_data, out_done_flag, out_result_valid, out_beat_count all 0; in_ready 0 during reset.
//   Reset mid-job: aborts the job and clears all delay lines; no done or result_valid is emitted.
//   Accept when in_valid && in_ready. in_ready = 1 in IDLE and FEED, 0 otherwise.
//   Skew: a beat accepted at cycle t appears on row r of out_data at cycle t+1+r.
//   A cycle in FEED with no accept injects 0 into row 0. All-zero FP is harmless to the accumulation.
//   Idle padding: outside FEED, the delay-line input is 0.
//   States and transitions:
//     IDLE:  accept && !in_last -> FEED.  accept && in_last -> FLUSH (single-beat job).
//     FEED:  accept && in_last -> FLUSH.
//     FLUSH: counts ROWS cycles -> DRAIN.
//     DRAIN: counts DRAIN_CYCLES -> DONE.
//     DONE:  out_result_valid = 1 for exactly one cycle -> IDLE.
//   Done flag: last beat accepted at t_l => out_done_flag[r] = 1 for exactly one cycle at t_l+2+r.
//   FLUSH therefore ends with row ROWS-1's flag.
//   Beat counter: cleared on the first accept of a job and +1 per accept.
//   It saturates at MAX_BEATS and holds its value after the job until the next job starts.
//   All outputs are registered. No combinational path from in_* to out_*, except in_ready, which depends only on state.
// CONFIGURATION
//   FEEDER_STALL_COUNT_EN defined: adds output out_stall_count [15:0].
//     It counts FEED cycles with no accept, saturates at 16'hFFFF, and clears on reset and on a job's first accept.
//   FEEDER_STALL_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//   Package systolic_pkg:
//     - feeder_state_t enum {IDLE, FEED, FLUSH, DRAIN, DONE}
//     - FP_ZERO constant
//     - shared WIDTH/ROWS defaults used by the processing_element build
//   Sub-module skew_delay_line #(WIDTH, DEPTH):
//     - DEPTH-stage register chain with synchronous reset, DEPTH = 0 is a wire
//     - instantiated per row with DEPTH = r for data and for the done bit
//   Top level holds the FSM, the counters and the row-0 mux (accepted data or zero).
// TESTING
//   1. ROWS=4, 3 back-to-back beats A,B,C (C in_last) accepted at t=1..3:
//      row0 shows A,B,C at t=2..4 and row3 at t=5..7; done[0]@5, done[3]@8; result_valid@8+DRAIN_CYCLES+1; beat_count=3.
//   2. Single beat with in_last accepted from IDLE at t=1:
//      FSM goes straight to FLUSH; done[r]@3+r; one result_valid; beat_count=1.
//   3. in_valid low for 2 cycles between beats 1 and 2:
//      two zero vectors are inserted on every row in skewed order; in_ready stays 1.
//      With FEEDER_STALL_COUNT_EN, out_stall_count=2.
//   4. in_valid held high through FLUSH/DRAIN: in_ready=0 and no beat is accepted.
//      The next job's first beat is accepted in the cycle after result_valid.
//   5. reset asserted for 1 cycle mid-FEED: the next cycle has all outputs 0 and state IDLE.
//      Zeros only leave the delay lines; no done or result_valid appears afterwards.
//   6. MAX_BEATS=3 with 5 beats: beat_count saturates at 3; the data stream still carries all 5 vectors.

Source files
------------

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic array front end.
//   - feeder_state_t : edge-feeder job FSM states
//   - FP_ZERO        : all-zero floating-point pattern (harmless to accumulation)
//   - DEFAULT_WIDTH / DEFAULT_ROWS : build defaults shared with processing_element
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_ROWS  = 4;

  // Wide enough for the FP32 build; narrower builds take the low slice.
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
//   DEPTH-stage register chain with synchronous active-high reset.
//   DEPTH = 0 degenerates to a plain wire.
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; clears every stage
//   d_i    in   [WIDTH-1:0] chain input
//   q_o    out  [WIDTH-1:0] input delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not only the head, so an aborted job
    // cannot leak stale operands into the array after reset releases.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// systolic_edge_feeder
//   West-edge transmitter for the systolic PE array. Accepts one ROWS-wide
//   operand vector per beat (valid/ready), re-times it into the diagonal skew
//   (row r delayed by r), pads idle/stall cycles with zero, emits a skewed
//   per-row done pulse after the last beat, waits out the PE drain latency and
//   then strobes out_result_valid for one cycle.
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready depends on state only)
//   in_data           ROWS*WIDTH, element r at [r*WIDTH +: WIDTH]
//   in_last           marks the final vector of a job
//   out_data          skewed stream, row r slice
//   out_done_flag     per-row one-cycle done pulse
//   out_busy          FSM not in IDLE
//   out_result_valid  one-cycle strobe: accumulators are final
//   out_beat_count    beats accepted in current/last job, saturating
//   out_stall_count   [15:0] FEED cycles without accept (only with
//                     FEEDER_STALL_COUNT_EN defined)
// Configuration
//   FEEDER_STALL_COUNT_EN : adds the stall counter and out_stall_count.
// -----------------------------------------------------------------------------
module systolic_edge_feeder
  import systolic_pkg::*;
#(
  parameter  int WIDTH        = DEFAULT_WIDTH,
  parameter  int ROWS         = DEFAULT_ROWS,
  parameter  int DRAIN_CYCLES = 8,
  parameter  int MAX_BEATS    = 255,
  localparam int BEAT_W       = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [ROWS*WIDTH-1:0] out_data,
  output logic [ROWS-1:0]       out_done_flag,
  output logic                  out_busy,
  output logic                  out_result_valid,
  output logic [BEAT_W-1:0]     out_beat_count
`ifdef FEEDER_STALL_COUNT_EN
  ,
  output logic [15:0]           out_stall_count
`endif
);

  localparam int CNT_MAX = (ROWS > DRAIN_CYCLES) ? ROWS : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  feeder_state_t          state_q;
  logic [CNT_W-1:0]       phase_cnt_q;
  logic                   last_q;
  logic                   result_valid_q;
  logic [BEAT_W-1:0]      beat_cnt_q;
  logic [ROWS*WIDTH-1:0]  row_dly;
  logic [ROWS-1:0]        done_dly;
  logic [ROWS*WIDTH-1:0]  out_data_q;
  logic [ROWS-1:0]        done_q;
  logic                   accept;
  logic                   first_accept;

  assign in_ready     = !reset && (state_q == IDLE || state_q == FEED);
  assign accept       = in_valid && in_ready;
  assign first_accept = accept && (state_q == IDLE);

  // FLUSH lasts until row ROWS-1's done flag is on the output (entry cycle
  // plus ROWS more); DRAIN then counts DRAIN_CYCLES before DONE.
  // NOTE: all state here is sequential, so only non-blocking assignments are
  // used; blocking ones would make later reads see this cycle's new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      phase_cnt_q    <= '0;
      last_q         <= 1'b0;
      result_valid_q <= 1'b0;
      beat_cnt_q     <= '0;
    end else begin
      last_q         <= accept && in_last;
      result_valid_q <= 1'b0;

      if (first_accept) begin
        beat_cnt_q <= BEAT_W'(1);
      end else if (accept && beat_cnt_q != BEAT_W'(MAX_BEATS)) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end

      unique case (state_q)
        IDLE:  if (accept) state_q <= in_last ? FLUSH : FEED;
        FEED:  if (accept && in_last) state_q <= FLUSH;
        FLUSH: begin
          if (phase_cnt_q == CNT_W'(ROWS)) begin
            state_q     <= DRAIN;
            phase_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (phase_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
            state_q        <= DONE;
            phase_cnt_q    <= '0;
            result_valid_q <= 1'b1;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FEEDER_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || first_accept) begin
      stall_cnt_q <= '0;
    end else if (state_q == FEED && !accept && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign out_stall_count = stall_cnt_q;
`endif

  // Per-row skew. Any cycle without an accept (stall in FEED, or outside
  // FEED) injects zero, which the PEs accumulate harmlessly.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WIDTH-1:0] src_d;
    assign src_d = accept ? in_data[r*WIDTH +: WIDTH] : FP_ZERO[WIDTH-1:0];

    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(r)) u_data (
      .clk   (clk),
      .reset (reset),
      .d_i   (src_d),
      .q_o   (row_dly[r*WIDTH +: WIDTH])
    );

    // last_q already adds one cycle, so flags trail the final beat's data by one.
    skew_delay_line #(.WIDTH(1), .DEPTH(r)) u_done (
      .clk   (clk),
      .reset (reset),
      .d_i   (last_q),
      .q_o   (done_dly[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
      done_q     <= '0;
    end else begin
      out_data_q <= row_dly;
      done_q     <= done_dly;
    end
  end

  assign out_data         = out_data_q;
  assign out_done_flag    = done_q;
  assign out_busy         = (state_q != IDLE);
  assign out_result_valid = result_valid_q;
  assign out_beat_count   = beat_cnt_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_edge_feeder
//   Scoreboard bench for systolic_edge_feeder. Two instances share stimulus:
//   the default build and one with MAX_BEATS=3 for beat-count saturation.
//   Expected row data, done flags and result strobes are queued with the
//   cycle they are due when a beat is driven, and retired on that cycle.
// -----------------------------------------------------------------------------
module tb_systolic_edge_feeder;

  localparam int WIDTH     = 16;
  localparam int ROWS      = 4;
  localparam int DRAIN     = 8;
  localparam int SAT_BEATS = 3;
  localparam int DW        = ROWS * WIDTH;
  localparam int LAT       = ROWS + DRAIN + 2;  // last accept -> result_valid

  logic          clk = 1'b0;
  logic          reset, in_valid, in_last;
  logic [DW-1:0] in_data;

  logic          in_ready, in_ready_sat;
  logic [DW-1:0] out_data, out_data_sat;
  logic [ROWS-1:0] done, done_sat;
  logic          busy, busy_sat, rv, rv_sat;
  logic [7:0]    beat;
  logic [1:0]    beat_sat;
`ifdef FEEDER_STALL_COUNT_EN
  logic [15:0]   stall, stall_sat;
`endif

  systolic_edge_feeder #(.WIDTH(WIDTH), .ROWS(ROWS), .DRAIN_CYCLES(DRAIN), .MAX_BEATS(255)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data),
    .out_done_flag(done), .out_busy(busy), .out_result_valid(rv),
    .out_beat_count(beat)
`ifdef FEEDER_STALL_COUNT_EN
    , .out_stall_count(stall)
`endif
  );

  systolic_edge_feeder #(.WIDTH(WIDTH), .ROWS(ROWS), .DRAIN_CYCLES(DRAIN), .MAX_BEATS(SAT_BEATS)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_sat),
    .in_data(in_data), .in_last(in_last), .out_data(out_data_sat),
    .out_done_flag(done_sat), .out_busy(busy_sat), .out_result_valid(rv_sat),
    .out_beat_count(beat_sat)
`ifdef FEEDER_STALL_COUNT_EN
    , .out_stall_count(stall_sat)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {EV_DATA, EV_DONE, EV_RESULT} ev_kind_e;
  typedef struct {
    int               cyc;
    ev_kind_e         kind;
    int               row;
    logic [WIDTH-1:0] val;
  } ev_t;

  ev_t sb[$];

  int cyc;
  int blocked_until;
  int exp_beats, exp_beats_sat;
  bit in_job, exp_busy;
`ifdef FEEDER_STALL_COUNT_EN
  int exp_stall;
`endif
  int n_vec, n_bad;

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*WIDTH +: WIDTH] = 16'($urandom_range(1, 65535));
    return v;
  endfunction

  // One clock: drive inputs, update the model/scoreboard, advance, retire due entries.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic last, input logic rst);
    logic rdy_exp, acc;
    logic [DW-1:0] exp_data;
    logic [ROWS-1:0] exp_done;
    logic exp_rv;
    ev_t ev;
    in_valid = v; in_data = d; in_last = last; reset = rst;
    #1;
    rdy_exp = !rst && (cyc > blocked_until);
    n_vec++;
    if (in_ready !== rdy_exp) begin
      n_bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, rdy_exp);
    end
    acc = v && rdy_exp;
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > cyc) sb.delete(i);
      blocked_until = -1; in_job = 0; exp_beats = 0; exp_beats_sat = 0;
`ifdef FEEDER_STALL_COUNT_EN
      exp_stall = 0;
`endif
    end else if (acc) begin
      for (int r = 0; r < ROWS; r++) begin
        ev.cyc = cyc + 1 + r; ev.kind = EV_DATA; ev.row = r; ev.val = d[r*WIDTH +: WIDTH];
        sb.push_back(ev);
      end
      if (!in_job) begin
        exp_beats = 1; exp_beats_sat = 1;
`ifdef FEEDER_STALL_COUNT_EN
        exp_stall = 0;
`endif
      end else begin
        if (exp_beats < 255) exp_beats++;
        if (exp_beats_sat < SAT_BEATS) exp_beats_sat++;
      end
      if (last) begin
        for (int r = 0; r < ROWS; r++) begin
          ev.cyc = cyc + 2 + r; ev.kind = EV_DONE; ev.row = r; ev.val = '0;
          sb.push_back(ev);
        end
        ev.cyc = cyc + LAT; ev.kind = EV_RESULT; ev.row = 0; ev.val = '0;
        sb.push_back(ev);
        blocked_until = cyc + LAT;
        in_job = 0;
      end else begin
        in_job = 1;
      end
    end else if (in_job) begin
`ifdef FEEDER_STALL_COUNT_EN
      if (exp_stall < 65535) exp_stall++;
`endif
    end
    exp_busy = !rst && (in_job || (cyc + 1) <= blocked_until);

    @(posedge clk);
    cyc++;
    #2;
    exp_data = '0; exp_done = '0; exp_rv = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          EV_DATA:   exp_data[sb[i].row*WIDTH +: WIDTH] = sb[i].val;
          EV_DONE:   exp_done[sb[i].row] = 1'b1;
          EV_RESULT: exp_rv = 1'b1;
          default:   ;
        endcase
        sb.delete(i);
      end
    end
    n_vec++;
    if (out_data !== exp_data) begin n_bad++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
    n_vec++;
    if (out_data_sat !== exp_data) begin n_bad++; $display("FAIL out_data_sat cyc=%0d got=%h exp=%h", cyc, out_data_sat, exp_data); end
    n_vec++;
    if (done !== exp_done) begin n_bad++; $display("FAIL done_flag cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
    n_vec++;
    if (rv !== exp_rv) begin n_bad++; $display("FAIL result_valid cyc=%0d got=%b exp=%b", cyc, rv, exp_rv); end
    n_vec++;
    if (busy !== exp_busy) begin n_bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
    n_vec++;
    if (beat !== 8'(exp_beats)) begin n_bad++; $display("FAIL beat_count cyc=%0d got=%0d exp=%0d", cyc, beat, exp_beats); end
    n_vec++;
    if (beat_sat !== 2'(exp_beats_sat)) begin n_bad++; $display("FAIL beat_count_sat cyc=%0d got=%0d exp=%0d", cyc, beat_sat, exp_beats_sat); end
`ifdef FEEDER_STALL_COUNT_EN
    n_vec++;
    if (stall !== 16'(exp_stall)) begin n_bad++; $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", cyc, stall, exp_stall); end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // in_valid high during reset must not be accepted
    step(1'b1, rand_vec(), 1'b0, 1'b1);
    step(1'b1, rand_vec(), 1'b1, 1'b1);
    n_vec++;
    if (out_data !== '0 || done !== '0 || rv !== 1'b0 || busy !== 1'b0 || beat !== 8'd0) begin
      n_bad++; $display("FAIL reset_state data=%h done=%b rv=%b busy=%b beat=%0d", out_data, done, rv, busy, beat);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    step(1'b1, rand_vec(), 1'b1, 1'b0);
    idle(1);
    n_vec++;
    if (done !== 4'b0001) begin n_bad++; $display("FAIL b2b_first_done got=%b exp=0001", done); end
    idle(LAT);
    n_vec++;
    if (beat !== 8'd3) begin n_bad++; $display("FAIL b2b_beat_count got=%0d exp=3", beat); end
  endtask

  task automatic test_single_beat();
    step(1'b1, rand_vec(), 1'b1, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_flush in_ready=%b busy=%b exp in_ready=0 busy=1", in_ready, busy);
    end
    idle(LAT + 1);
    n_vec++;
    if (beat !== 8'd1) begin n_bad++; $display("FAIL single_beat_count got=%0d exp=1", beat); end
  endtask

  task automatic test_stall();
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    idle(2);
    step(1'b1, rand_vec(), 1'b1, 1'b0);
    idle(LAT + 1);
`ifdef FEEDER_STALL_COUNT_EN
    n_vec++;
    if (stall !== 16'd2) begin n_bad++; $display("FAIL stall_count_final got=%0d exp=2", stall); end
`endif
    n_vec++;
    if (beat !== 8'd2) begin n_bad++; $display("FAIL stall_beat_count got=%0d exp=2", beat); end
  endtask

  task automatic test_hold_valid();
    logic [DW-1:0] held;
    held = rand_vec();
    step(1'b1, rand_vec(), 1'b1, 1'b0);
    for (int i = 0; i < LAT - 1; i++) step(1'b1, held, 1'b0, 1'b0);
    n_vec++;
    if (rv !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL hold_done_cycle rv=%b in_ready=%b exp rv=1 in_ready=0", rv, in_ready);
    end
    step(1'b1, held, 1'b0, 1'b0);
    step(1'b1, held, 1'b1, 1'b0);
    n_vec++;
    if (beat !== 8'd1) begin n_bad++; $display("FAIL hold_beat_count got=%0d exp=1", beat); end
    idle(LAT);
  endtask

  task automatic test_reset_mid_feed();
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    step(1'b1, rand_vec(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if (out_data !== '0 || done !== '0 || rv !== 1'b0 || busy !== 1'b0 || beat !== 8'd0) begin
      n_bad++; $display("FAIL midreset_state data=%h done=%b rv=%b busy=%b beat=%0d", out_data, done, rv, busy, beat);
    end
    idle(LAT + 2);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) step(1'b1, rand_vec(), (i == 4), 1'b0);
    idle(LAT + 1);
    n_vec++;
    if (beat !== 8'd5 || beat_sat !== 2'd3) begin
      n_bad++; $display("FAIL saturation beat=%0d beat_sat=%0d exp 5 and 3", beat, beat_sat);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    blocked_until = -1; in_job = 0; exp_busy = 0;
    exp_beats = 0; exp_beats_sat = 0;
`ifdef FEEDER_STALL_COUNT_EN
    exp_stall = 0;
`endif
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(posedge clk);
    #2;

    test_reset();
    test_back_to_back();
    test_single_beat();
    test_stall();
    test_hold_valid();
    test_reset_mid_feed();
    test_saturation();
    idle(4);

    n_vec++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
